// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: CPU-side address decode, read-return/open-bus steering and sprite DMA.
// One CPU cycle per clock; every slave returns read data one cycle after its address.
module cpu_bus_ctrl #(
   parameter int          RAM_ADDR_BITS = 11,
   parameter int          DMA_LEN       = 256,
   parameter logic [15:0] DMA_REG       = 16'h4014,
   parameter logic [2:0]  DMA_DST_REG   = 3'd4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [15:0]              cpu_ab,
   input  logic [7:0]               cpu_do,
   input  logic                     cpu_we,
   output logic [7:0]               cpu_di,
   output logic                     cpu_rdy,
   output logic [RAM_ADDR_BITS-1:0] ram_addr,
   output logic                     ram_we,
   output logic [7:0]               ram_wdata,
   input  logic [7:0]               ram_rdata,
   output logic [2:0]               ppu_reg,
   output logic                     ppu_we,
   output logic                     ppu_re,
   output logic [7:0]               ppu_wdata,
   input  logic [7:0]               ppu_rdata,
   output logic [4:0]               io_addr,
   output logic                     io_we,
   output logic                     io_re,
   output logic [7:0]               io_wdata,
   input  logic [7:0]               io_rdata,
   output logic [14:0]              prg_addr,
   output logic                     prg_we,
   output logic [7:0]               prg_wdata,
   input  logic [7:0]               prg_rdata,
   output logic                     dma_busy
);
   typedef enum logic [2:0] {ST_IDLE, ST_HALT, ST_ALIGN, ST_READ, ST_WRITE} dma_state_t;
   typedef enum logic [2:0] {SEL_NONE, SEL_RAM, SEL_PPU, SEL_IO, SEL_PRG} sel_t;

   localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);

   dma_state_t  state_r, state_nxt_s;
   sel_t        sel_r, sel_s;
   logic [7:0]  page_r, idx_r, ob_r, cpu_di_s;
   logic        parity_r;
   logic [15:0] m_addr_s;
   logic        m_rd_s, m_wr_s, dma_trig_s;

   // The DMA trigger register reads as open bus wherever it sits in the map.
   function automatic sel_t decode(input logic [15:0] a);
      sel_t s;
      if (a == DMA_REG)               s = SEL_NONE;
      else if (a[15:13] == 3'b000)    s = SEL_RAM;
      else if (a[15:13] == 3'b001)    s = SEL_PPU;
      else if (a[15:5] == 11'h200)    s = SEL_IO;
      else if (a[15] == 1'b1)         s = SEL_PRG;
      else                            s = SEL_NONE;
      return s;
   endfunction

   // Bus master selection: CPU in IDLE, DMA engine in READ, nobody otherwise.
   always_comb begin
      m_addr_s = cpu_ab;
      m_rd_s   = 1'b0;
      m_wr_s   = 1'b0;
      if (!reset && state_r == ST_IDLE) begin
         m_rd_s = !cpu_we;
         m_wr_s = cpu_we;
      end else if (!reset && state_r == ST_READ) begin
         m_addr_s = {page_r, idx_r};
         m_rd_s   = 1'b1;
      end else begin
         m_rd_s = 1'b0;
         m_wr_s = 1'b0;
      end
   end

   assign sel_s      = (m_rd_s || m_wr_s) ? decode(m_addr_s) : SEL_NONE;
   assign dma_trig_s = !reset && (state_r == ST_IDLE) && cpu_we && (cpu_ab == DMA_REG);

   // Read-return mux; unselected cycles replay the open-bus latch.
   always_comb begin
      case (sel_r)
         SEL_RAM: cpu_di_s = ram_rdata;
         SEL_PPU: cpu_di_s = ppu_rdata;
         SEL_IO:  cpu_di_s = io_rdata;
         SEL_PRG: cpu_di_s = prg_rdata;
         default: cpu_di_s = ob_r;
      endcase
   end

   assign cpu_di    = cpu_di_s;
   assign cpu_rdy   = (state_r == ST_IDLE);
   assign dma_busy  = (state_r != ST_IDLE);

   assign ram_addr  = m_addr_s[RAM_ADDR_BITS-1:0];
   assign ram_we    = m_wr_s && (sel_s == SEL_RAM);
   assign ram_wdata = cpu_do;

   assign ppu_reg   = (state_r == ST_WRITE) ? DMA_DST_REG : m_addr_s[2:0];
   assign ppu_we    = (m_wr_s && (sel_s == SEL_PPU)) || (state_r == ST_WRITE);
   assign ppu_re    = m_rd_s && (sel_s == SEL_PPU);
   assign ppu_wdata = (state_r == ST_WRITE) ? cpu_di_s : cpu_do;

   assign io_addr   = m_addr_s[4:0];
   assign io_we     = m_wr_s && (sel_s == SEL_IO);
   assign io_re     = m_rd_s && (sel_s == SEL_IO);
   assign io_wdata  = cpu_do;

   assign prg_addr  = m_addr_s[14:0];
   assign prg_we    = m_wr_s && (sel_s == SEL_PRG);
   assign prg_wdata = cpu_do;

   // DMA next-state logic; ALIGN pads the transfer onto the right CPU cycle parity.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:  if (dma_trig_s) state_nxt_s = ST_HALT; else state_nxt_s = ST_IDLE;
         ST_HALT:  if (parity_r) state_nxt_s = ST_ALIGN; else state_nxt_s = ST_READ;
         ST_ALIGN: state_nxt_s = ST_READ;
         ST_READ:  state_nxt_s = ST_WRITE;
         ST_WRITE: if (idx_r == IDX_LAST) state_nxt_s = ST_IDLE; else state_nxt_s = ST_READ;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // State, registered select, open-bus latch, parity toggle and DMA counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         sel_r    <= SEL_NONE;
         ob_r     <= 8'h00;
         parity_r <= 1'b0;
         page_r   <= 8'h00;
         idx_r    <= 8'h00;
      end else begin
         state_r  <= state_nxt_s;
         sel_r    <= sel_s;
         ob_r     <= cpu_di_s;
         parity_r <= ~parity_r;
         if (dma_trig_s) begin
            page_r <= cpu_do;
            idx_r  <= 8'h00;
         end else if (state_r == ST_WRITE) begin
            idx_r  <= (idx_r == IDX_LAST) ? 8'h00 : idx_r + 8'h01;
         end else begin
            idx_r  <= idx_r;
         end
      end
   end
endmodule

// File: doc/cpu_bus_ctrl.md
# cpu_bus_ctrl

Parametrised CPU-side bus controller for the NES core. It sits between the 6502 `cpu` instance and its slaves: work RAM, PPU registers, APU/IO registers and cartridge PRG space. It decodes and mirrors the 16-bit address bus and steers synchronous read data back to the CPU with open-bus behaviour. It also contains the sprite DMA engine (write to $4014), which halts the CPU via `cpu_rdy` and copies a page into PPU OAMDATA.

## Interface
Parameters:
- `RAM_ADDR_BITS`, default 11: work-RAM address width; RAM is mirrored across $0000–$1FFF. Legal range 8–13.
- `DMA_LEN`, default 256: bytes per DMA transfer. Legal range 1–256.
- `DMA_REG`, default 16'h4014: CPU write address that triggers DMA.
- `DMA_DST_REG`, default 3'd4: PPU register index written by DMA (OAMDATA).

Ports:
- `clk`  in  1  system clock; one CPU cycle per clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_ab`  in  16  CPU address bus.
- `cpu_do`  in  8  CPU write data.
- `cpu_we`  in  1  CPU write enable.
- `cpu_di`  out  8  CPU read data; valid the cycle after the address.
- `cpu_rdy`  out  1  CPU ready; 0 halts the CPU.
- `ram_addr`  out  RAM_ADDR_BITS  work-RAM address.
- `ram_we`, `ram_wdata`  out  1 / 8  work-RAM write strobe and data.
- `ram_rdata`  in  8  work-RAM read data (1-cycle synchronous).
- `ppu_reg`  out  3  PPU register index.
- `ppu_we`, `ppu_re`  out  1 / 1  PPU write / read strobes, one cycle each.
- `ppu_wdata`  out  8  PPU write data.
- `ppu_rdata`  in  8  PPU read data (1-cycle).
- `io_addr`  out  5  APU/IO register index.
- `io_we`, `io_re`, `io_wdata`  out  1 / 1 / 8  IO strobes and write data.
- `io_rdata`  in  8  IO read data (1-cycle).
- `prg_addr`  out  15  PRG address.
- `prg_we`, `prg_wdata`  out  1 / 8  mapper register write.
- `prg_rdata`  in  8  PRG read data (1-cycle).
- `dma_busy`  out  1  high while the DMA FSM is not in IDLE.

## Operation
- Address decode (combinational on the active bus master's address):
  - $0000–$1FFF: RAM; `ram_addr` = addr[RAM_ADDR_BITS-1:0].
  - $2000–$3FFF: PPU; `ppu_reg` = addr[2:0].
  - $4000–$401F: IO; `io_addr` = addr[4:0]. `DMA_REG` is excluded and handled internally.
  - $4020–$7FFF: unmapped.
  - $8000–$FFFF: PRG; `prg_addr` = addr[14:0].
- Strobes: `*_we` = master write AND select; `*_re` = master read AND select. Slaves share the master's write data.
- Read-return: the select decode is registered (`sel_q`), and `cpu_di` muxes the slave selected by `sel_q`.
- Open bus: for unmapped addresses or a `DMA_REG` read, `cpu_di` = last value driven on `cpu_di` (open-bus latch), updated every cycle.
- Parity toggle: a free-running 1-bit toggle flips every clock; reset value 0.
- DMA FSM states:
  - IDLE: the CPU owns the bus. A CPU write to `DMA_REG` latches `page` = `cpu_do` and goes to HALT. This write produces no IO strobe.
  - HALT: 1 cycle, no bus activity. Go to ALIGN if parity=1, else to READ.
  - ALIGN: 1 idle cycle, then READ.
  - READ: read strobe on address {page, idx}, decoded as above. Go to WRITE.
  - WRITE: `ppu_we` = 1, `ppu_reg` = `DMA_DST_REG`, `ppu_wdata` = the read-return mux output selected by `sel_q`. Then `idx`++. If `idx` was DMA_LEN-1, go to IDLE; else go to READ.
- While not in IDLE, CPU bus inputs are ignored: no CPU-originated strobes.
- `cpu_rdy` = 1 only in IDLE.
- DMA reads from an unmapped page return the open-bus value.

## Timing
- Reset values: FSM IDLE, `idx`=0, `page`=0, `sel_q`=unmapped, open-bus latch 0x00, `cpu_di`=0x00, `cpu_rdy`=1, `dma_busy`=0, all strobes 0.
- CPU read latency: 1 cycle (address in cycle N, data on `cpu_di` in cycle N+1).
- DMA duration, counted from the first cycle after the trigger write: 1 + align + 2·DMA_LEN cycles with `cpu_rdy`=0. For the default length this is 513 cycles (parity 0) or 514 cycles (parity 1). `cpu_rdy` returns to 1 in the cycle after the last WRITE.
- Reset mid-DMA: the FSM returns to IDLE immediately, `cpu_rdy`=1, and no further PPU writes occur.
- `idx` is DMA_LEN-bounded and never wraps past the page.

## Test plan
- Reset -> `cpu_rdy`=1, `dma_busy`=0, `cpu_di`=0x00, no strobes.
- Write 0x5A to $0805 with RAM_ADDR_BITS=11, then read $1805 -> `ram_addr`=0x005 both times; `cpu_di`=RAM data one cycle after the read.
- Read $3FF9 -> `ppu_re`=1 for one cycle, `ppu_reg`=1. Read $5000 -> no strobe, `cpu_di` holds the previous value.
- RAM preloaded 0x200+i = i. Write 0x02 to $4014 with parity 0 -> `cpu_rdy` low 513 cycles; 256 `ppu_we` pulses at reg 4 with data 0x00..0xFF in order.
- Same DMA with trigger at parity 1 -> `cpu_rdy` low 514 cycles, same data.
- Assert `reset` after the 10th DMA PPU write -> `cpu_rdy`=1 at once, no further `ppu_we`, next CPU read serviced normally.
